// File: rtl/btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// btn_debounce_multi
//
// Multi-channel push-button conditioner. Each channel is polarity-corrected,
// passed through a two-flop synchroniser and debounced by a counter that needs
// STABLE_TICKS consecutive disagreeing sample ticks to flip the clean level.
// A single shared prescaler produces the sample tick, so every channel samples
// on the same cycles. Optionally, a per-channel hold-to-repeat FSM re-emits
// press pulses while the button stays down.
//
// Handshake/strobe semantics: there is no valid/ready pairing here. btn_press
// and btn_release are one-cycle strobes that are high exactly in the first
// cycle btn_level shows the new value (or, for repeats, in the cycle after
// the tick that completes the repeat interval). tick is a one-cycle strobe
// that is high in the cycle before the edge on which debouncing samples.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       [N_CH] raw asynchronous button inputs
//   btn_level    [N_CH] debounced level, 1 = pressed
//   btn_press    [N_CH] one-cycle pulse on debounced press (and each repeat)
//   btn_release  [N_CH] one-cycle pulse on debounced release
//   tick         one-cycle sample strobe
//
// Debug: the repeat FSM state of channel g is g_ch[g].g_rep.state_q.
// -----------------------------------------------------------------------------
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 125000,
  parameter int STABLE_TICKS = 4,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            tick
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int CW   = $clog2(STABLE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] RDLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_e;

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_w;

  always_comb begin
    tick_w  = (presc_q == PRESC_LAST);
    presc_d = tick_w ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign tick = tick_w;

  // ---------------------------------------------------------------------------
  // Polarity correction and two-flop synchroniser (reset = released)
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] in_pol;
  logic [N_CH-1:0] sync1_q, sync2_q;

  assign in_pol = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_pol;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce, edge pulses and optional repeat
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_w, fall_w;
    logic          rep_pulse_w;
    logic          press_q, release_q;

    // Any agreeing cycle clears the count, so a single glitch back to the
    // current level throws away everything accumulated so far.
    always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      rise_w = 1'b0;
      fall_w = 1'b0;
      if (sync2_q[g] == lvl_q) begin
        cnt_d = '0;
      end else if (tick_w) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d  = sync2_q[g];
          cnt_d  = '0;
          rise_w = sync2_q[g];
          fall_w = ~sync2_q[g];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        lvl_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        lvl_q     <= lvl_d;
        press_q   <= rise_w | rep_pulse_w;
        release_q <= fall_w;
      end
    end

    if (REPEAT_EN != 0) begin : g_rep
      rep_state_e    state_q;
      logic [RW-1:0] rcnt_q;
      logic          hit_w;

      // A falling level on the same tick wins: no repeat pulse alongside a
      // release.
      always_comb begin
        hit_w = 1'b0;
        if (tick_w && !fall_w) begin
          case (state_q)
            R_DELAY:  hit_w = (rcnt_q == RDLY_LAST);
            R_REPEAT: hit_w = (rcnt_q == RRATE_LAST);
            default:  hit_w = 1'b0;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= R_IDLE;
          rcnt_q  <= '0;
        end else if (fall_w) begin
          state_q <= R_IDLE;
          rcnt_q  <= '0;
        end else begin
          case (state_q)
            R_IDLE: begin
              if (rise_w) begin
                state_q <= R_DELAY;
                rcnt_q  <= '0;
              end
            end
            R_DELAY: begin
              if (tick_w) begin
                if (hit_w) begin
                  state_q <= R_REPEAT;
                  rcnt_q  <= '0;
                end else begin
                  rcnt_q <= rcnt_q + RW'(1);
                end
              end
            end
            R_REPEAT: begin
              if (tick_w) begin
                if (hit_w) rcnt_q <= '0;
                else       rcnt_q <= rcnt_q + RW'(1);
              end
            end
            default: begin
              state_q <= R_IDLE;
              rcnt_q  <= '0;
            end
          endcase
        end
      end

      assign rep_pulse_w = hit_w;
    end else begin : g_norep
      assign rep_pulse_w = 1'b0;
    end

    assign btn_level[g]   = lvl_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_multi
//
// Two instances share clock and reset:
//   dut0: active-high inputs, no repeat
//   dut1: active-low inputs, repeat enabled
// Stimulus pushes hand-computed pulse events {cycle, level, release, press}
// into per-instance expected queues; a monitor on the falling edge pops and
// compares whenever an instance shows a pulse, flags events whose cycle has
// passed, and checks tick and the steady level every cycle.
// -----------------------------------------------------------------------------
module tb_btn_debounce_multi;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int W  = 22;  // {cyc[15:0], level[1:0], release[1:0], press[1:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic [N-1:0] btn0, lvl0, prs0, rel0;
  logic [N-1:0] btn1, lvl1, prs1, rel1;
  logic         tick0, tick1;

  btn_debounce_multi #(
    .N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(0),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn0), .btn_level(lvl0),
    .btn_press(prs0), .btn_release(rel0), .tick(tick0)
  );

  btn_debounce_multi #(
    .N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn1), .btn_level(lvl1),
    .btn_press(prs1), .btn_release(rel1), .tick(tick1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic [1:0]   exp_lvl [2];
  int tests = 0;
  int fails = 0;

  // First rising edge that samples a synchroniser value driven after edge c.
  function automatic int ft(input int c);
    int n;
    n = c + 3;
    while (n % TD != 0) n++;
    return n;
  endfunction

  // Cycle in which the debounced level flips for an input driven after edge c.
  function automatic int exp_at(input int c);
    return ft(c) + TD * (ST - 1);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp0_q.size() : exp1_q.size();
  endfunction

  function automatic int peek_cyc(input int d);
    logic [W-1:0] e;
    e = (d == 0) ? exp0_q[0] : exp1_q[0];
    return int'(e[21:6]);
  endfunction

  task automatic pop(input int d, output logic [W-1:0] e);
    if (d == 0) e = exp0_q.pop_front();
    else        e = exp1_q.pop_front();
  endtask

  task automatic push(input int d, input int c, input logic [1:0] p,
                      input logic [1:0] r, input logic [1:0] l);
    logic [W-1:0] e;
    logic [15:0]  c16;
    c16 = c[15:0];
    e = {c16, l, r, p};
    if (d == 0) exp0_q.push_back(e);
    else        exp1_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic [1:0] p, input logic [1:0] r,
                     input logic [1:0] l);
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic [15:0]  c16;
    while (qsize(d) > 0 && peek_cyc(d) < cyc) begin
      pop(d, e);
      tests++;
      fails++;
      $display("FAIL dut%0d missed_event: expected press=%b release=%b level=%b at cycle %0d, nothing seen",
               d, e[1:0], e[3:2], e[5:4], e[21:6]);
    end
    c16 = cyc[15:0];
    got = {c16, l, r, p};
    if ((p | r) != 2'b00) begin
      tests++;
      if (qsize(d) == 0) begin
        fails++;
        $display("FAIL dut%0d unexpected_pulse: got press=%b release=%b level=%b at cycle %0d, expected none",
                 d, p, r, l, cyc);
      end else begin
        pop(d, e);
        exp_lvl[d] = e[5:4];
        if (got !== e) begin
          fails++;
          $display("FAIL dut%0d pulse: got press=%b release=%b level=%b cycle %0d, expected press=%b release=%b level=%b cycle %0d",
                   d, p, r, l, cyc, e[1:0], e[3:2], e[5:4], e[21:6]);
        end
      end
    end else begin
      tests++;
      if (l !== exp_lvl[d]) begin
        fails++;
        $display("FAIL dut%0d level: got %b expected %b (cycle %0d)", d, l, exp_lvl[d], cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_lvl[0] = 2'b00;
      exp_lvl[1] = 2'b00;
    end else begin
      chk("tick0", {1'b0, tick0}, {1'b0, (cyc % TD) == (TD - 1)});
      chk("tick1", {1'b0, tick1}, {1'b0, (cyc % TD) == (TD - 1)});
      mon(0, prs0, rel0, lvl0);
      mon(1, prs1, rel1, lvl1);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int c, c2, p_cyc, r_cyc, r;
    btn0  = 2'b00;
    btn1  = 2'b11;  // active-low: released
    rst_n = 1'b0;
    step(3);

    // Reset state
    chk("rst_level0",   lvl0, 2'b00);
    chk("rst_press0",   prs0, 2'b00);
    chk("rst_release0", rel0, 2'b00);
    chk("rst_tick0",    {1'b0, tick0}, 2'b00);
    chk("rst_level1",   lvl1, 2'b00);
    chk("rst_press1",   prs1, 2'b00);
    chk("rst_release1", rel1, 2'b00);
    chk("rst_tick1",    {1'b0, tick1}, 2'b00);
    rst_n = 1'b1;

    // Clean press on ch0, held long enough that a repeat would show up
    step(2);
    c = cyc;
    btn0[0] = 1'b1;
    push(0, exp_at(c), 2'b01, 2'b00, 2'b01);
    step(exp_at(c) - c + 30);

    // Release
    c = cyc;
    btn0[0] = 1'b0;
    push(0, exp_at(c), 2'b00, 2'b01, 2'b00);
    step(exp_at(c) - c + 5);

    // Bounce: toggle every 3 clk for 39 clk, last toggle leaves it high
    c = cyc;
    for (int i = 0; i < 13; i++) begin
      btn0[0] = ~btn0[0];
      c = cyc;
      step(3);
    end
    push(0, exp_at(c), 2'b01, 2'b00, 2'b01);
    step(exp_at(c) - cyc + 5);

    // Release after bounce
    c = cyc;
    btn0[0] = 1'b0;
    push(0, exp_at(c), 2'b00, 2'b01, 2'b00);
    step(exp_at(c) - c + 5);

    // Reset mid-count: ch0 pressed, ch1 two ticks into its count
    c = cyc;
    btn0[0] = 1'b1;
    push(0, exp_at(c), 2'b01, 2'b00, 2'b01);
    step(exp_at(c) - c + 5);
    c = cyc;
    btn0[1] = 1'b1;
    step(ft(c) + TD + 1 - c);
    rst_n = 1'b0;
    #1;
    chk("midrst_level0",   lvl0, 2'b00);
    chk("midrst_press0",   prs0, 2'b00);
    chk("midrst_release0", rel0, 2'b00);
    chk("midrst_tick0",    {1'b0, tick0}, 2'b00);
    step(2);
    rst_n = 1'b1;
    // Both held buttons re-detected as if driven at cycle 0
    push(0, exp_at(0), 2'b11, 2'b00, 2'b11);
    step(exp_at(0) + 5);
    c = cyc;
    btn0 = 2'b00;
    push(0, exp_at(c), 2'b00, 2'b11, 2'b00);
    step(exp_at(c) - c + 5);

    // Active-low, simultaneous press and release on both channels of dut1
    c = cyc;
    btn1 = 2'b00;
    p_cyc = exp_at(c);
    push(1, p_cyc, 2'b11, 2'b00, 2'b11);
    step(p_cyc + 1 - c);
    c = cyc;
    btn1 = 2'b11;
    push(1, exp_at(c), 2'b00, 2'b11, 2'b00);
    step(exp_at(c) - c + 5);

    // Hold-to-repeat on dut1 ch0 for about 40 ticks
    c = cyc;
    btn1[0] = 1'b0;
    p_cyc = exp_at(c);
    c2 = p_cyc + 157;
    r_cyc = exp_at(c2);
    push(1, p_cyc, 2'b01, 2'b00, 2'b01);
    for (r = p_cyc + RD * TD; r < r_cyc; r += RR * TD)
      push(1, r, 2'b01, 2'b00, 2'b01);
    push(1, r_cyc, 2'b00, 2'b01, 2'b00);
    step(c2 - c);
    btn1[0] = 1'b1;
    step(r_cyc - c2 + 2 * RR * TD + 4);

    // Every expected event must have been consumed
    tests++;
    if (exp0_q.size() != 0) begin
      fails++;
      $display("FAIL dut0 leftover: %0d expected events never seen, required 0", exp0_q.size());
    end
    tests++;
    if (exp1_q.size() != 0) begin
      fails++;
      $display("FAIL dut1 leftover: %0d expected events never seen, required 0", exp1_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner for the board-level inputs feeding the UART transmit trigger and other user controls. Each channel synchronises a raw asynchronous button, debounces it with a counter that requires a configurable number of consecutive stable sample ticks, and produces a clean level, single-cycle press/release pulses and an optional hold-to-repeat press stream. A single shared prescaler generates the sample tick, so all channels sample on the same cycles.

## Interface
- N_CH, 4, number of independent button channels (>=1)
- TICK_DIV, 125000, clk cycles per sample tick (>=2); prescaler width = $clog2(TICK_DIV)
- STABLE_TICKS, 4, consecutive disagreeing ticks required to flip the debounced level (>=1)
- ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed; inverted before synchronisation
- REPEAT_EN, 0, 1 = enable auto-repeat press pulses while held
- REPEAT_DELAY, 500, ticks from press to first repeat pulse (>=1)
- REPEAT_RATE, 100, ticks between subsequent repeat pulses (>=1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_in  input  N_CH  raw asynchronous button inputs
- btn_level  output  N_CH  debounced level, 1 = pressed
- btn_press  output  N_CH  one-cycle pulse on debounced press (and each repeat)
- btn_release  output  N_CH  one-cycle pulse on debounced release
- tick  output  1  one-cycle sample strobe (debug/observability)

## Operation
- Polarity: in_n = ACTIVE_LOW ? ~btn_in : btn_in, per channel.
- Synchroniser: two flops per channel; sync = second stage. Reset value 0 (released).
- Prescaler: counts 0..TICK_DIV-1, wraps to 0; tick = 1 in cycles where count == TICK_DIV-1. Reset 0.
- Per-channel stable counter cnt (width $clog2(STABLE_TICKS+1)):
  - any cycle sync == btn_level: cnt <= 0
  - tick && sync != btn_level && cnt < STABLE_TICKS-1: cnt <= cnt+1
  - tick && sync != btn_level && cnt == STABLE_TICKS-1: btn_level <= sync, cnt <= 0
- A single agreeing cycle (glitch back) discards all accumulated count.
- btn_press/btn_release registered; high exactly in the first cycle btn_level shows the new value.
- Repeat (REPEAT_EN=1), per channel, states IDLE/DELAY/REPEAT:
  - IDLE -> DELAY on level rise; rcnt <= 0
  - DELAY: count ticks; at REPEAT_DELAY-th tick pulse btn_press, rcnt <= 0, -> REPEAT
  - REPEAT: pulse btn_press every REPEAT_RATE ticks
  - any state -> IDLE on level fall (release pulse still emitted)
- REPEAT_EN=0: repeat FSM and counters absent; one press per press.
- Channels fully independent; simultaneous events on different channels produce simultaneous pulses.

## Timing
- Reset (async assert, sync release path through flops): btn_level, btn_press, btn_release, tick = 0; all counters 0; FSMs IDLE.
- Reset mid-operation: all state cleared immediately; a button held through reset is re-detected as a fresh press after STABLE_TICKS ticks.
- First tick: cycle TICK_DIV-1 after reset release (prescaler starts at 0).
- Input-to-sync latency: 2 clk.
- Press latency: sync change -> btn_level change at the STABLE_TICKS-th following tick, +1 clk for register update; worst case 2 + STABLE_TICKS*TICK_DIV + 1 clk.
- Edge arriving at sync in the same cycle as tick: counted on that tick.
- Pulses are exactly one clk wide; never back-to-back on one channel unless REPEAT_RATE*TICK_DIV == 1 (illegal, TICK_DIV>=2).
- STABLE_TICKS=1: level flips on the first tick that sees disagreement.

## Test plan
Params N_CH=2, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2 unless stated.
- Clean press: btn_in[0] 0->1 and held -> btn_level[0] rises after 3 ticks (<=15 clk), one btn_press[0] pulse in that cycle, channel 1 unaffected.
- Bounce: btn_in[0] toggles every 3 clk for 40 clk then settles high -> no level change during bouncing, exactly one press pulse 3 ticks after settling.
- Release: from pressed, btn_in[0] 1->0 held -> btn_level[0] falls after 3 ticks, one btn_release[0] pulse, no press pulse.
- Repeat (REPEAT_EN=1): hold channel 0 for 40 ticks -> press at T0, then at T0+5 ticks, then every 2 ticks; releasing stops repeats, single release pulse.
- Reset mid-count: assert rst_n=0 after 2 disagreeing ticks, release with button held -> all outputs 0 immediately, press pulse 3 ticks after reset release.
- ACTIVE_LOW=1, simultaneous: both btn_in driven 1->0 in same cycle -> both btn_level rise and both btn_press pulse in the same cycle.
